// File: rtl/walksat_pkg.sv
// walksat_pkg: shared definitions for the WalkSAT sequencing controller.
// Control-word layout, FSM state encoding and LFSR feedback.
package walksat_pkg;

  localparam int CTRL_W    = 20;
  localparam int B_INIT    = 0;
  localparam int B_PICK    = 1;
  localparam int B_BREAK   = 2;
  localparam int B_FLIP    = 3;
  localparam int B_SEL_MIN = 4;
  localparam int LIT_LO    = 5;
  localparam int LIT_HI    = 6;
  localparam int RAND_LO   = 7;
  localparam int RAND_HI   = 17;
  localparam int LIT_W     = LIT_HI - LIT_LO + 1;
  localparam int RAND_W    = RAND_HI - RAND_LO + 1;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    PICK,
    BREAK,
    FLIP,
    DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

  function automatic logic [CTRL_W-1:0] ctrl_word(
    input logic              op_init,
    input logic              op_pick,
    input logic              op_break,
    input logic              op_flip,
    input logic              sel_min,
    input logic [LIT_W-1:0]  lit,
    input logic [RAND_W-1:0] rnd
  );
    logic [CTRL_W-1:0] w;
    w                   = '0;
    w[B_INIT]           = op_init;
    w[B_PICK]           = op_pick;
    w[B_BREAK]          = op_break;
    w[B_FLIP]           = op_flip;
    w[B_SEL_MIN]        = sel_min;
    w[LIT_HI:LIT_LO]    = lit;
    w[RAND_HI:RAND_LO]  = rnd;
    return w;
  endfunction

endpackage

// File: rtl/walksat_lfsr.sv
// walksat_lfsr: free-running 16-bit Galois LFSR.
// Advances every cycle; reloads SEED on synchronous reset.
module walksat_lfsr
  import walksat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= lfsr_next(state);
  end

endmodule

// File: rtl/walksat_controller.sv
// walksat_controller: sequences the datapath through the WalkSAT loop.
// Moore outputs; ops are held until the datapath acknowledges.
module walksat_controller
  import walksat_pkg::*;
#(
  parameter int          NSAT                    = 3,
  parameter int          CONTROLLER_SIGNAL_WIDTH = 20,
  parameter logic [15:0] LFSR_SEED               = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic [8:0]                         noise_p_i,
  input  logic [31:0]                        max_flips_i,
  input  logic                               dp_ready_i,
  input  logic                               unsat_empty_i,
  input  logic                               break_zero_i,
  output logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o,
  output logic                               done_o,
  output logic                               sat_o,
  output logic [31:0]                        flip_count_o
);

  localparam logic [LIT_W-1:0] LAST_LIT = LIT_W'(NSAT - 1);
  localparam logic [LIT_W:0]   NSAT_L   = (LIT_W + 1)'(NSAT);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              done_q, done_d;
  logic              sat_q, sat_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       budget_q, budget_d;
  logic [15:0]       lfsr;
  logic [LIT_W-1:0]  lit_q;
  logic [LIT_W:0]    raw_lit;
  logic [LIT_W:0]    rnd_lit;
  logic              go_random;

  walksat_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  assign lit_q     = ctrl_q[LIT_HI:LIT_LO];
  assign raw_lit   = {1'b0, lfsr[15:14]};
  assign rnd_lit   = (raw_lit >= NSAT_L) ? raw_lit - NSAT_L : raw_lit;
  assign go_random = {1'b0, lfsr[7:0]} < noise_p_i;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    done_d   = done_q;
    sat_d    = sat_q;
    count_d  = count_q;
    budget_d = budget_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = INIT;
          ctrl_d   = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
          done_d   = 1'b0;
          sat_d    = 1'b0;
          count_d  = '0;
          budget_d = max_flips_i;
        end
      end
      INIT: begin
        if (dp_ready_i) begin
          state_d = CHECK;
          ctrl_d  = '0;
        end
      end
      CHECK: begin
        ctrl_d = '0;
        if (unsat_empty_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          sat_d   = 1'b1;
        end else if (count_q >= budget_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          sat_d   = 1'b0;
        end else begin
          state_d = PICK;
          ctrl_d  = ctrl_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,
                              lfsr[RAND_W-1:0]);
        end
      end
      PICK: begin
        if (dp_ready_i) begin
          if (go_random) begin
            state_d = FLIP;
            ctrl_d  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                rnd_lit[LIT_W-1:0], '0);
          end else begin
            state_d = BREAK;
            ctrl_d  = ctrl_word(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
          end
        end
      end
      BREAK: begin
        if (dp_ready_i) begin
          // a zero-break literal is flipped at once, skipping the scan
          if (break_zero_i) begin
            state_d = FLIP;
            ctrl_d  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lit_q, '0);
          end else if (lit_q == LAST_LIT) begin
            state_d = FLIP;
            ctrl_d  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
          end else begin
            ctrl_d  = ctrl_word(1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                lit_q + 1'b1, '0);
          end
        end
      end
      FLIP: begin
        if (dp_ready_i) begin
          state_d = CHECK;
          ctrl_d  = '0;
          if (count_q != '1) count_d = count_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      budget_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      budget_q <= budget_d;
    end
  end

  assign control_signal_o = CONTROLLER_SIGNAL_WIDTH'(ctrl_q);
  assign done_o           = done_q;
  assign sat_o            = sat_q;
  assign flip_count_o     = count_q;

endmodule

// File: tb/tb_walksat_controller.sv
// tb_walksat_controller: directed checks of the WalkSAT controller.
// Expected words are hand-derived; RAND/LIT use a reference LFSR.
module tb_walksat_controller;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [8:0]  noise_p_i;
  logic [31:0] max_flips_i;
  logic        dp_ready_i;
  logic        unsat_empty_i;
  logic        break_zero_i;
  logic [19:0] control_signal_o;
  logic        done_o;
  logic        sat_o;
  logic [31:0] flip_count_o;

  int errs   = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  walksat_controller #(
    .NSAT                    (3),
    .CONTROLLER_SIGNAL_WIDTH (20),
    .LFSR_SEED               (SEED)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .noise_p_i        (noise_p_i),
    .max_flips_i      (max_flips_i),
    .dp_ready_i       (dp_ready_i),
    .unsat_empty_i    (unsat_empty_i),
    .break_zero_i     (break_zero_i),
    .control_signal_o (control_signal_o),
    .done_o           (done_o),
    .sat_o            (sat_o),
    .flip_count_o     (flip_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? SEED : ref_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          n;
  logic        was_pick;
  logic [1:0]  elit;
  logic [31:0] ew;

  initial begin
    reset         = 1'b1;
    start_i       = 1'b0;
    noise_p_i     = 9'd0;
    max_flips_i   = 32'd0;
    dp_ready_i    = 1'b1;
    unsat_empty_i = 1'b0;
    break_zero_i  = 1'b0;
    tick();
    tick();
    check("rst_word", 32'(control_signal_o), 32'h0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sat", 32'(sat_o), 32'd0);
    check("rst_cnt", flip_count_o, 32'd0);
    reset = 1'b0;

    // already satisfied
    unsat_empty_i = 1'b1;
    max_flips_i   = 32'd5;
    start_i       = 1'b1;
    tick();
    check("a_init", 32'(control_signal_o), 32'h001);
    start_i = 1'b0;
    tick();
    check("a_check", 32'(control_signal_o), 32'h000);
    tick();
    check("a_done", 32'(done_o), 32'd1);
    check("a_sat", 32'(sat_o), 32'd1);
    check("a_cnt", flip_count_o, 32'd0);

    // zero budget, unsatisfied
    unsat_empty_i = 1'b0;
    max_flips_i   = 32'd0;
    start_i       = 1'b1;
    tick();
    check("b_init", 32'(control_signal_o), 32'h001);
    check("b_done_clr", 32'(done_o), 32'd0);
    start_i = 1'b0;
    tick();
    check("b_check", 32'(control_signal_o), 32'h000);
    tick();
    check("b_done", 32'(done_o), 32'd1);
    check("b_sat", 32'(sat_o), 32'd0);
    tick();
    check("b_hold_word", 32'(control_signal_o), 32'h000);
    check("b_hold_done", 32'(done_o), 32'd1);

    // one greedy iteration, full scan
    max_flips_i = 32'd1;
    noise_p_i   = 9'd0;
    start_i     = 1'b1;
    tick();
    check("c_init", 32'(control_signal_o), 32'h001);
    start_i = 1'b0;
    tick();
    check("c_check", 32'(control_signal_o), 32'h000);
    tick();
    ew = (32'(m_prev[10:0]) << 7) | 32'h2;
    check("c_pick", 32'(control_signal_o), ew);
    tick();
    check("c_brk0", 32'(control_signal_o), 32'h004);
    tick();
    check("c_brk1", 32'(control_signal_o), 32'h024);
    tick();
    check("c_brk2", 32'(control_signal_o), 32'h044);
    tick();
    check("c_flip", 32'(control_signal_o), 32'h018);
    tick();
    check("c_check2", 32'(control_signal_o), 32'h000);
    check("c_cnt1", flip_count_o, 32'd1);
    tick();
    check("c_done", 32'(done_o), 32'd1);
    check("c_sat", 32'(sat_o), 32'd0);
    check("c_cnt", flip_count_o, 32'd1);

    // freebie at LIT 1, then stall and reset in BREAK
    max_flips_i = 32'd10;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    check("d_pick", 32'(control_signal_o[3:0]), 32'h2);
    tick();
    check("d_brk0", 32'(control_signal_o), 32'h004);
    tick();
    check("d_brk1", 32'(control_signal_o), 32'h024);
    break_zero_i = 1'b1;
    tick();
    check("d_freebie", 32'(control_signal_o), 32'h028);
    break_zero_i = 1'b0;
    tick();
    check("d_check", 32'(control_signal_o), 32'h000);
    check("d_cnt", flip_count_o, 32'd1);
    tick();
    tick();
    check("d_brk0b", 32'(control_signal_o), 32'h004);
    dp_ready_i = 1'b0;
    start_i    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start_i = 1'b0;
      check("d_stall", 32'(control_signal_o), 32'h004);
    end
    reset = 1'b1;
    tick();
    check("d_rst_word", 32'(control_signal_o), 32'h000);
    check("d_rst_done", 32'(done_o), 32'd0);
    check("d_rst_cnt", flip_count_o, 32'd0);
    reset      = 1'b0;
    dp_ready_i = 1'b1;

    // always-random moves
    noise_p_i   = 9'd256;
    max_flips_i = 32'd1000;
    start_i     = 1'b1;
    tick();
    start_i  = 1'b0;
    was_pick = 1'b0;
    n        = 0;
    while (!done_o && n < 5000) begin
      tick();
      n++;
      if (control_signal_o[2])
        check("e_no_break", 32'(control_signal_o[2]), 32'd0);
      if (was_pick) begin
        elit = (m_prev[15:14] == 2'd3) ? 2'd0 : m_prev[15:14];
        ew   = 32'h8 | (32'(elit) << 5);
        check("e_flip", 32'(control_signal_o), ew);
      end
      was_pick = control_signal_o[1];
    end
    check("e_timeout", 32'(done_o), 32'd1);
    check("e_sat", 32'(sat_o), 32'd0);
    check("e_cnt", flip_count_o, 32'd1000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/walksat_controller.md
# walksat_controller

Sequencing FSM that drives the 20-bit `control_signal_i` word of the SAT-solver datapath through the WalkSAT loop: initial clause evaluation, check, unsat-clause pick, break-value scan, flip. It consumes datapath status (ready, unsat-buffer-empty, zero-break) and decides greedy versus random moves using an internal LFSR. It sits beside the datapath under the solver top. Problem loading is complete before `start_i`.

## Interface
- `NSAT`, 3, literals per clause; legal range 2..4.
- `CONTROLLER_SIGNAL_WIDTH`, 20, control word width; fixed at 20.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin solve; honoured only in IDLE or DONE.
- `noise_p_i`  in  9  random-move threshold; 0 = never random, 256 = always random.
- `max_flips_i`  in  32  flip budget; sampled at start.
- `dp_ready_i`  in  1  datapath finished the asserted op.
- `unsat_empty_i`  in  1  datapath unsat-clause buffer is empty.
- `break_zero_i`  in  1  break value of the literal being scanned is 0; valid with `dp_ready_i` in BREAK.
- `control_signal_o`  out  20  control word to the datapath.
- `done_o`  out  1  solve finished; held until the next start.
- `sat_o`  out  1  result; valid while `done_o` = 1.
- `flip_count_o`  out  32  flips performed; saturates at 2^32-1.

## Operation
- Control word fields:
  - [0] OP_INIT
  - [1] OP_PICK
  - [2] OP_BREAK
  - [3] OP_FLIP
  - [4] FLIP_SEL_MIN: 1 = flip the min-break literal; 0 = flip the LIT field.
  - [6:5] LIT
  - [17:7] RAND: index into the unsat buffer.
  - [19:18] are always 0.
- States:
  - IDLE: word 0. On `start_i`, go to INIT; clear `done_o`, `sat_o` and the count; latch `max_flips_i`.
  - INIT: OP_INIT. On ready, go to CHECK.
  - CHECK: one cycle, word 0.
    - If `unsat_empty_i`: go to DONE with `sat_o` = 1.
    - Else if count >= budget: go to DONE with `sat_o` = 0.
    - Else: go to PICK with RAND = lfsr[10:0].
  - PICK: OP_PICK. On ready, sample r = lfsr[7:0].
    - If {1'b0,r} < `noise_p_i`: go to FLIP with SEL_MIN = 0 and LIT = lfsr[15:14] reduced mod NSAT (value >= NSAT becomes value - NSAT).
    - Else: go to BREAK with LIT = 0.
  - BREAK: OP_BREAK with LIT = k. On ready:
    - If `break_zero_i` (freebie): go to FLIP with LIT = k and SEL_MIN = 0.
    - Else if k = NSAT-1: go to FLIP with SEL_MIN = 1.
    - Else: LIT = k+1, stay in BREAK.
  - FLIP: OP_FLIP. On ready, increment the count (saturating) and go to CHECK.
  - DONE: `done_o` = 1. On `start_i`, behave as IDLE does on start.
- `start_i` outside IDLE/DONE is ignored.
- `dp_ready_i` is ignored in IDLE, CHECK and DONE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle, including IDLE.

## Timing
- All outputs are registered (Moore).
- Reset values: `control_signal_o` 0, `done_o` 0, `sat_o` 0, `flip_count_o` 0, state IDLE, LFSR = `LFSR_SEED`.
- Start accepted at edge N: OP_INIT is visible in cycle N+1.
- Handshake is level req/ack: the op bits and fields stay stable while `dp_ready_i` = 0.
  - The word changes in the cycle after `dp_ready_i` is sampled 1.
  - Ready in the same cycle the op first appears is legal (one-cycle op).
- Minimum greedy iteration: CHECK 1 + PICK 1 + BREAK NSAT + FLIP 1 cycles.
- Reset mid-operation: the next cycle shows all reset values; any in-flight op is abandoned.
- `max_flips_i` = 0 gives DONE straight from the first CHECK unless the buffer is empty, in which case `sat_o` = 1.
- When the buffer is empty and the budget is exhausted in the same CHECK, SAT wins.

## Structure
- Package `walksat_pkg`:
  - control-word bit/field positions
  - `CTRL_W` = 20
  - state enum {IDLE, INIT, CHECK, PICK, BREAK, FLIP, DONE}
  - LFSR taps
- Sub-module `walksat_lfsr`: inputs clk, reset; parameter SEED; output 16-bit state.
- The FSM, counters and control-word register live in `walksat_controller`.

## Test plan
- `dp_ready_i` = 1, `unsat_empty_i` = 1, start → INIT for 1 cycle, then CHECK, then DONE; `sat_o` = 1, count 0.
- `max_flips_i` = 0, `unsat_empty_i` = 0 → DONE with `sat_o` = 0 and OP_PICK never asserted.
- `noise_p_i` = 0, `break_zero_i` = 0, `max_flips_i` = 1 → word sequence 0x001, 0, PICK (bit1 + RAND), BREAK with LIT 0/1/2, 0x018 (FLIP+SEL_MIN), 0; DONE with `sat_o` = 0, count 1.
- `noise_p_i` = 256 → PICK is always followed by FLIP with SEL_MIN = 0 and LIT < 3; no BREAK is ever seen over 1000 flips.
- `break_zero_i` = 1 at LIT = 1 → the next word is FLIP with LIT = 1, SEL_MIN = 0; LIT = 2 is never issued.
- `dp_ready_i` held 0 for 5 cycles in BREAK → word unchanged; `reset` asserted mid-BREAK → next cycle word 0, `done_o` 0, count 0.
